// File: rtl/rst_seq_multi.sv
// rst_seq_multi -- parametrised clock-generator reset sequencer.
//
// Holds NUM_LOCK clock generators in reset, waits for all of their LOCKED
// flags, requires the locks to stay stable, then releases NUM_OUT downstream
// resets one at a time (bit 0 first). A lock timeout re-pulses the generator
// reset and bumps a saturating retry counter. A lock loss after release has
// started re-runs the whole sequence.
//
// Optional build macro: RSTSEQ_LOCK_FILTER_EN
//   When defined, a lock loss in RELEASE/RUN is declared only after the
//   synchronised lock AND has been low for LOSS_FILT_CYC consecutive cycles.
//   When undefined, a single low cycle is a lock loss.
//
// Ports:
//   CLK_50M    in   1         block clock
//   SYS_RST    in   1         synchronous reset, active-high
//   LOCKED_IN  in   NUM_LOCK  asynchronous generator lock flags
//   DCM_RST    out  1         reset to all clock generators, active-high
//   RST_OUT    out  NUM_OUT   staged resets, active-high, bit 0 released first
//   ALL_LOCKED out  1         synchronised AND of LOCKED_IN
//   SEQ_DONE   out  1         high while every RST_OUT bit is released
//   RETRY_CNT  out  8         lock-timeout retries, saturating at 255
module rst_seq_multi #(
  parameter int NUM_LOCK      = 2,
  parameter int NUM_OUT       = 3,
  parameter int CNT_W         = 16,
  parameter int DCM_RST_CYC   = 16,
  parameter int STABLE_CYC    = 16,
  parameter int STAGE_CYC     = 16,
  parameter int LOCK_TMO_CYC  = 50000,
  parameter int LOSS_FILT_CYC = 4
) (
  input  logic                CLK_50M,
  input  logic                SYS_RST,
  input  logic [NUM_LOCK-1:0] LOCKED_IN,
  output logic                DCM_RST,
  output logic [NUM_OUT-1:0]  RST_OUT,
  output logic                ALL_LOCKED,
  output logic                SEQ_DONE,
  output logic [7:0]          RETRY_CNT
);

`ifdef RSTSEQ_LOCK_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  // Unfiltered build behaves as a filter of length one.
  localparam int LOSS_LEN = FILT_EN ? LOSS_FILT_CYC : 1;
  localparam int IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    S_RESET_DCM,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [CNT_W-1:0]     filt_reg, filt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [NUM_OUT-1:0]   rst_out_reg, rst_out_next;
  logic                 dcm_rst_reg, dcm_rst_next;
  logic                 seq_done_reg, seq_done_next;
  logic [7:0]           retry_reg, retry_next;
  logic [NUM_LOCK-1:0]  lk_meta_reg, lk_sync_reg;
  logic                 all_lk;
  logic                 lock_loss;

  // Two-flop synchroniser per lock flag; bits are combined only after the
  // second stage so a metastable first stage never feeds the AND.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOCK; gi++) begin : g_sync
      always_ff @(posedge CLK_50M) begin
        if (SYS_RST) begin
          lk_meta_reg[gi] <= 1'b0;
          lk_sync_reg[gi] <= 1'b0;
        end else begin
          lk_meta_reg[gi] <= LOCKED_IN[gi];
          lk_sync_reg[gi] <= lk_meta_reg[gi];
        end
      end
    end
  endgenerate

  assign all_lk = &lk_sync_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    rst_out_next  = rst_out_reg;
    seq_done_next = seq_done_reg;
    retry_next    = retry_reg;
    filt_next     = '0;
    lock_loss     = 1'b0;

    case (state_reg)
      S_RESET_DCM: begin
        rst_out_next  = '1;
        seq_done_next = 1'b0;
        if (cnt_reg == DCM_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout on the same cycle.
        if (all_lk) begin
          state_next = S_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TMO_LAST) begin
          state_next = S_RESET_DCM;
          cnt_next   = '0;
          if (retry_reg != 8'hFF) retry_next = retry_reg + 8'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_STABLE: begin
        if (!all_lk) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = S_RELEASE;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      S_RELEASE, S_RUN: begin
        // filt_reg counts consecutive low cycles seen so far; a loss is
        // declared on the LOSS_LEN-th low cycle.
        if (!all_lk) begin
          if (filt_reg == LOSS_LAST) lock_loss = 1'b1;
          else                       filt_next = filt_reg + CNT_W'(1);
        end

        if (lock_loss) begin
          state_next    = S_RESET_DCM;
          cnt_next      = '0;
          rst_out_next  = '1;
          seq_done_next = 1'b0;
          filt_next     = '0;
        end else if (state_reg == S_RELEASE) begin
          if (cnt_reg == STAGE_LAST) begin
            rst_out_next[idx_reg] = 1'b0;
            cnt_next              = '0;
            if (idx_reg == LAST_IDX) begin
              state_next    = S_RUN;
              seq_done_next = 1'b1;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = S_RESET_DCM;
        cnt_next   = '0;
      end
    endcase

    dcm_rst_next = (state_next == S_RESET_DCM);
  end

  always_ff @(posedge CLK_50M) begin
    if (SYS_RST) begin
      state_reg    <= S_RESET_DCM;
      cnt_reg      <= '0;
      filt_reg     <= '0;
      idx_reg      <= '0;
      rst_out_reg  <= '1;
      dcm_rst_reg  <= 1'b1;
      seq_done_reg <= 1'b0;
      retry_reg    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      filt_reg     <= filt_next;
      idx_reg      <= idx_next;
      rst_out_reg  <= rst_out_next;
      dcm_rst_reg  <= dcm_rst_next;
      seq_done_reg <= seq_done_next;
      retry_reg    <= retry_next;
    end
  end

  assign DCM_RST    = dcm_rst_reg;
  assign RST_OUT    = rst_out_reg;
  assign ALL_LOCKED = all_lk;
  assign SEQ_DONE   = seq_done_reg;
  assign RETRY_CNT  = retry_reg;

endmodule

// File: tb/tb_rst_seq_multi.sv
// tb_rst_seq_multi -- directed bench for rst_seq_multi with
// NUM_LOCK=2, NUM_OUT=3, DCM_RST_CYC=4, STABLE_CYC=8, STAGE_CYC=4,
// LOCK_TMO_CYC=32, LOSS_FILT_CYC=4. Honours RSTSEQ_LOCK_FILTER_EN.
module tb_rst_seq_multi;

`ifdef RSTSEQ_LOCK_FILTER_EN
  localparam int LOSS_LEN = 4;
`else
  localparam int LOSS_LEN = 1;
`endif

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [1:0] locked_in;
  logic       dcm_rst;
  logic [2:0] rst_out;
  logic       all_locked;
  logic       seq_done;
  logic [7:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  rst_seq_multi #(
    .NUM_LOCK(2), .NUM_OUT(3), .CNT_W(16), .DCM_RST_CYC(4), .STABLE_CYC(8),
    .STAGE_CYC(4), .LOCK_TMO_CYC(32), .LOSS_FILT_CYC(4)
  ) dut (
    .CLK_50M(clk), .SYS_RST(sys_rst), .LOCKED_IN(locked_in),
    .DCM_RST(dcm_rst), .RST_OUT(rst_out), .ALL_LOCKED(all_locked),
    .SEQ_DONE(seq_done), .RETRY_CNT(retry_cnt)
  );

  typedef struct {
    logic       srst;
    logic [1:0] lk;
    logic       dcm;
    logic [2:0] rst;
    logic       al;
    logic       sd;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic srst, input logic [1:0] lk, input logic dcm,
                     input logic [2:0] rst, input logic al, input logic sd,
                     input logic [7:0] rc, input int n);
    vec_t v;
    v.srst = srst; v.lk = lk; v.dcm = dcm; v.rst = rst;
    v.al = al; v.sd = sd; v.rc = rc;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic dcm, input logic [2:0] rst,
                            input logic al, input logic sd, input logic [7:0] rc);
    chk({name, ".dcm"}, {31'd0, dcm_rst}, {31'd0, dcm});
    chk({name, ".rst"}, {29'd0, rst_out}, {29'd0, rst});
    chk({name, ".al"},  {31'd0, all_locked}, {31'd0, al});
    chk({name, ".sd"},  {31'd0, seq_done}, {31'd0, sd});
    chk({name, ".rc"},  {24'd0, retry_cnt}, {24'd0, rc});
  endtask

  task automatic do_reset(input logic [1:0] lk);
    sys_rst   = 1'b1;
    locked_in = lk;
    repeat (3) tick();
    sys_rst = 1'b0;
  endtask

  // Full resequence after a lock-loss edge L, all locks steady high:
  // DCM_RST high L..L+3, RELEASE entered at L+13, bits clear at +17/+21/+25.
  task automatic check_reseq(input string name);
    logic [2:0] er;
    for (int k = 1; k <= 25; k++) begin
      tick();
      er = (k < 17) ? 3'b111 : (k < 21) ? 3'b110 : (k < 25) ? 3'b100 : 3'b000;
      chk($sformatf("%s.dcm%0d", name, k), {31'd0, dcm_rst}, {31'd0, (k <= 3)});
      chk($sformatf("%s.rst%0d", name, k), {29'd0, rst_out}, {29'd0, er});
      chk($sformatf("%s.sd%0d", name, k), {31'd0, seq_done}, {31'd0, (k >= 25)});
    end
    $display("%s: resequence done rst=%b sd=%b", name, rst_out, seq_done);
  endtask

  initial begin
    logic [2:0] er;
    logic       hit;

    sys_rst   = 1'b1;
    locked_in = 2'b11;

    // ---- Test 1: nominal bring-up, table driven ----
    add(1, 2'b11, 1, 3'b111, 0, 0, 8'd0, 3);   // reset cycles
    add(0, 2'b11, 1, 3'b111, 0, 0, 8'd0, 1);   // E1: sync still filling
    add(0, 2'b11, 1, 3'b111, 1, 0, 8'd0, 2);   // E2,E3
    add(0, 2'b11, 0, 3'b111, 1, 0, 8'd0, 13);  // E4..E16 wait/stable/release
    add(0, 2'b11, 0, 3'b110, 1, 0, 8'd0, 4);   // E17..E20
    add(0, 2'b11, 0, 3'b100, 1, 0, 8'd0, 4);   // E21..E24
    add(0, 2'b11, 0, 3'b000, 1, 1, 8'd0, 3);   // E25..E27 RUN

    for (int i = 0; i < vecs.size(); i++) begin
      sys_rst   = vecs[i].srst;
      locked_in = vecs[i].lk;
      tick();
      check_outs($sformatf("t1_v%0d", i), vecs[i].dcm, vecs[i].rst,
                 vecs[i].al, vecs[i].sd, vecs[i].rc);
      $display("t1 vec %0d: srst=%b lk=%b -> dcm=%b rst=%b al=%b sd=%b rc=%0d",
               i, vecs[i].srst, vecs[i].lk, dcm_rst, rst_out, all_locked,
               seq_done, retry_cnt);
    end

    // ---- Test 4: lock loss in RUN ----
`ifdef RSTSEQ_LOCK_FILTER_EN
    // A 3-cycle dropout is shorter than the filter and must be ignored.
    locked_in = 2'b10;
    repeat (3) tick();
    chk("t4_short_al", {31'd0, all_locked}, 32'd0);
    locked_in = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t4_short_rst%0d", k), {29'd0, rst_out}, 32'd0);
      chk($sformatf("t4_short_sd%0d", k), {31'd0, seq_done}, 32'd1);
    end
    $display("t4: short dropout ignored rst=%b", rst_out);
`endif
    locked_in = 2'b10;
    repeat (LOSS_LEN) tick();
    chk("t4_drop_rst", {29'd0, rst_out}, 32'd0);
    locked_in = 2'b11;
    tick();
    check_outs("t4_pre", 1'b0, 3'b000, 1'b0, 1'b1, 8'd0);
    tick();
    check_outs("t4_loss", 1'b1, 3'b111, 1'b1, 1'b0, 8'd0);
    $display("t4: lock loss -> rst=%b sd=%b dcm=%b", rst_out, seq_done, dcm_rst);
    check_reseq("t4_reseq");

    // ---- Test 3: stability abort ----
    do_reset(2'b11);
    for (int e = 1; e <= 23; e++) begin
      locked_in = (e == 8) ? 2'b01 : 2'b11;
      tick();
      er = (e >= 23) ? 3'b110 : 3'b111;
      chk($sformatf("t3_dcm%0d", e), {31'd0, dcm_rst}, {31'd0, (e <= 3)});
      chk($sformatf("t3_rst%0d", e), {29'd0, rst_out}, {29'd0, er});
      chk($sformatf("t3_al%0d", e), {31'd0, all_locked}, {31'd0, (e >= 2 && e != 9)});
    end
    $display("t3: abort then release rst=%b", rst_out);

    // ---- Test 2: lock timeout, one lock missing ----
    do_reset(2'b01);
    for (int e = 1; e <= 110; e++) begin
      tick();
      chk($sformatf("t2_dcm%0d", e), {31'd0, dcm_rst}, {31'd0, ((e % 36) < 4)});
      chk($sformatf("t2_rc%0d", e), {24'd0, retry_cnt}, e / 36);
      chk($sformatf("t2_rst%0d", e), {29'd0, rst_out}, 32'd7);
    end
    $display("t2: after timeouts rc=%0d rst=%b", retry_cnt, rst_out);

    // ---- Test 5: SYS_RST mid-RELEASE ----
    locked_in = 2'b11;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      tick();
      if (rst_out == 3'b110) hit = 1'b1;
    end
    chk("t5_reach_release", {31'd0, hit}, 32'd1);
    chk("t5_rc_kept", {24'd0, retry_cnt}, 32'd3);
    tick();
    sys_rst = 1'b1;
    tick();
    check_outs("t5_rst", 1'b1, 3'b111, 1'b0, 1'b0, 8'd0);
    $display("t5: reset mid-release rst=%b dcm=%b rc=%0d", rst_out, dcm_rst, retry_cnt);

    // ---- Test 6: retry counter saturation ----
    do_reset(2'b00);
    for (int e = 1; e <= 9362; e++) begin
      tick();
      if (e == 9179) chk("t6_rc254", {24'd0, retry_cnt}, 32'd254);
      if (e == 9180) chk("t6_rc255", {24'd0, retry_cnt}, 32'd255);
    end
    chk("t6_sat", {24'd0, retry_cnt}, 32'd255);
    chk("t6_rst", {29'd0, rst_out}, 32'd7);
    $display("t6: saturation rc=%0d", retry_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_multi.md
Name: rst_seq_multi

Overview:
- Parametrised reset sequencer; successor to the fixed two-DCM, 16-cycle clock/reset block.
- Drives the reset of NUM_LOCK clock generators and monitors their LOCKED flags.
- Releases NUM_OUT downstream resets in a staged order.
- Retries a generator reset on lock timeout and re-sequences on lock loss. Runs in the 50 MHz input domain.

Parameters:
- NUM_LOCK, 2, number of LOCKED inputs monitored.
- NUM_OUT, 3, number of staged reset outputs.
- CNT_W, 16, width of the shared cycle counter; all *_CYC values must be < 2^CNT_W.
- DCM_RST_CYC, 16, cycles DCM_RST is held high per attempt (min 1).
- STABLE_CYC, 16, cycles all locks must stay high before release starts (min 1).
- STAGE_CYC, 16, cycles between successive RST_OUT releases (min 1).
- LOCK_TMO_CYC, 50000, WAIT_LOCK cycles before retry (min 2).
- LOSS_FILT_CYC, 4, lock-loss filter length; used only with the optional feature.

Ports:
- CLK_50M, in, 1, block clock.
- SYS_RST, in, 1, synchronous reset, active-high.
- LOCKED_IN, in, NUM_LOCK, asynchronous generator lock flags.
- DCM_RST, out, 1, reset to all clock generators, active-high.
- RST_OUT, out, NUM_OUT, staged resets, active-high; bit 0 is released first.
- ALL_LOCKED, out, 1, synchronised AND of LOCKED_IN.
- SEQ_DONE, out, 1, high while every RST_OUT is released.
- RETRY_CNT, out, 8, number of lock-timeout retries, saturating.

Behaviour:
- All outputs are registered.
- Reset (SYS_RST=1 at an edge):
  - state=RESET_DCM, counter=0, stage index=0, sync flops=0.
  - DCM_RST=1, RST_OUT=all ones, SEQ_DONE=0, ALL_LOCKED=0, RETRY_CNT=0.
  - SYS_RST overrides all state in any state, mid-sequence included.
- Synchronisation:
  - Each LOCKED_IN bit passes through a 2-flop synchroniser.
  - all_lk = AND of the synced bits; ALL_LOCKED = all_lk, giving 2 cycles latency from a LOCKED_IN edge.
- RESET_DCM:
  - DCM_RST=1, RST_OUT=all ones, SEQ_DONE=0.
  - Counter runs 0..DCM_RST_CYC-1, then goes to WAIT_LOCK with counter=0.
  - DCM_RST is therefore high for exactly DCM_RST_CYC cycles per attempt.
- WAIT_LOCK:
  - DCM_RST=0; counter increments each cycle.
  - all_lk=1 -> STABLE, counter=0.
  - Else counter==LOCK_TMO_CYC-1 -> RETRY_CNT+1 (holds at 255), -> RESET_DCM, counter=0.
  - If all_lk rises on the timeout cycle, lock wins and the state goes to STABLE.
- STABLE:
  - all_lk=0 in any cycle -> WAIT_LOCK, counter=0; the timeout restarts.
  - counter==STABLE_CYC-1 with all_lk=1 -> RELEASE, counter=0, idx=0.
- RELEASE:
  - Counter increments each cycle.
  - At counter==STAGE_CYC-1: clear RST_OUT[idx], counter=0, idx+1.
  - When idx reaches NUM_OUT-1 and that bit is cleared -> RUN; SEQ_DONE goes 1 in the same cycle as the last bit clears.
  - RST_OUT[k] first reads 0 exactly (k+1)*STAGE_CYC cycles after RELEASE entry.
  - Released bits stay 0 until a lock loss or SYS_RST.
- RUN: hold outputs; SEQ_DONE=1.
- Lock loss in RELEASE or RUN (see Optional Feature for the trigger):
  - Next cycle: RST_OUT=all ones, SEQ_DONE=0, state=RESET_DCM, counter=0.
  - RETRY_CNT is not incremented.
- Width rules: counter is CNT_W bits and never wraps, because every terminal compare is below 2^CNT_W. The idx width is clog2(NUM_OUT), minimum 1.
- NUM_OUT=1: RELEASE lasts STAGE_CYC cycles, then RUN.

Optional Feature:
- Macro: RSTSEQ_LOCK_FILTER_EN.
- Defined: lock loss in RELEASE/RUN is declared only after all_lk=0 for LOSS_FILT_CYC consecutive cycles. Any high cycle clears the filter count. The filter count is zeroed on SYS_RST and on entry to RELEASE.
- Undefined: a single cycle of all_lk=0 in RELEASE/RUN is a lock loss, and LOSS_FILT_CYC is unused.
- STABLE behaviour is identical in both builds.

Test Plan (NUM_LOCK=2, NUM_OUT=3, DCM_RST_CYC=4, STABLE_CYC=8, STAGE_CYC=4, LOCK_TMO_CYC=32):
1. Nominal bring-up: SYS_RST for 3 cycles, LOCKED_IN=2'b11 held high.
   -> DCM_RST high for 4 cycles after SYS_RST falls.
   -> RST_OUT[0]/[1]/[2] release at RELEASE entry +4/+8/+12 cycles.
   -> SEQ_DONE=1 at +12; RETRY_CNT=0.
2. Lock timeout: LOCKED_IN=2'b01 held.
   -> After 32 WAIT_LOCK cycles DCM_RST re-pulses for 4 cycles and RETRY_CNT=1.
   -> After 3 attempts RETRY_CNT=3; RST_OUT stays 3'b111 throughout.
3. Stability abort: locks high for 5 cycles in STABLE, then bit 1 low for 1 cycle.
   -> Return to WAIT_LOCK; RELEASE starts only after a further 8 clean cycles.
   -> DCM_RST not pulsed.
4. Lock loss in RUN: LOCKED_IN[0] low for 1 cycle.
   -> Without filter: RST_OUT=3'b111 and SEQ_DONE=0 on the cycle after ALL_LOCKED falls, then a full resequence.
   -> With RSTSEQ_LOCK_FILTER_EN (LOSS_FILT_CYC=4): a 3-cycle dropout is ignored; a 4-cycle dropout triggers resequence.
5. Reset mid-RELEASE: SYS_RST=1 after RST_OUT[0] has released.
   -> Next cycle RST_OUT=3'b111, DCM_RST=1, RETRY_CNT=0, ALL_LOCKED=0.
6. Saturation: force 260 timeouts -> RETRY_CNT holds at 255.
